// File: rtl/mfcc_pkg.sv
// rtl/mfcc_pkg.sv - shared defaults, state enumeration and sample conversion for the MFCC framer
package mfcc_pkg;

    localparam int FRAME_LEN_DEF    = 256;
    localparam int HOP_DEF          = 128;
    localparam int PREEMP_SHIFT_DEF = 5;
    localparam int DEPTH_DEF        = 2 * FRAME_LEN_DEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // Offset-binary 12-bit ADC code to a signed 16-bit sample
    function automatic logic signed [15:0] adc_to_s16(input logic [11:0] x);
        return {{4{~x[11]}}, ~x[11], x[10:0]};
    endfunction

endpackage

// File: rtl/framer_ram.sv
// rtl/framer_ram.sv - simple dual-port sample buffer, one write port, registered read
module framer_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = 16
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_q;

    // Write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: one cycle from address to data
    always_ff @(posedge i_clk) begin
        r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/mfcc_framer.sv
// rtl/mfcc_framer.sv - ADC sample conversion, pre-emphasis and overlapping frame streaming
module mfcc_framer
    import mfcc_pkg::*;
#(
    parameter int FRAME_LEN    = FRAME_LEN_DEF,
    parameter int HOP          = HOP_DEF,
    parameter int PREEMP_SHIFT = PREEMP_SHIFT_DEF
) (
    input  logic        hclk,
    input  logic        rst,
    input  logic        enable,
    input  logic        double,
    input  logic [23:0] din,
    input  logic        din_vld,
    output logic [15:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_first,
    output logic        m_last,
    output logic        overflow,
    output logic [15:0] frame_cnt
);

    localparam int              C_DEPTH    = 2 * FRAME_LEN;
    localparam int              AW         = $clog2(C_DEPTH);
    localparam int              LW         = $clog2(FRAME_LEN);
    localparam logic [AW:0]     C_DEPTH_P  = (AW+1)'(C_DEPTH);
    localparam logic [AW:0]     C_FRAME_P  = (AW+1)'(FRAME_LEN);
    localparam logic [AW:0]     C_HOP_P    = (AW+1)'(HOP);
    localparam logic [LW-1:0]   C_LAST_IDX = LW'(FRAME_LEN - 1);

    state_t             r_state, w_state_next;
    logic [AW:0]        r_wr_ptr, r_base, w_base_next, w_occ;
    logic [LW-1:0]      r_idx, w_idx_next;
    logic               w_clear, w_xfer, w_frame_done;
    logic               r_pend;
    logic [11:0]        r_pend_x;
    logic signed [15:0] r_prev, w_s, w_y;
    logic               w_word, w_wr_go, w_wr_ok, w_wr_full;
    logic [11:0]        w_wr_x;
    logic [AW-1:0]      w_raddr;
    logic [15:0]        w_rdata;
    logic               r_ovf;
    logic [15:0]        r_frame_cnt;

    // Occupancy uses the extra wrap bit so a full buffer is distinguishable from empty
    assign w_occ        = r_wr_ptr - r_base;
    assign w_xfer       = (r_state == ST_STREAM) && m_ready;
    assign w_frame_done = w_xfer && (r_idx == C_LAST_IDX);

    // Next state, frame base and read index; clearing wins over everything else
    always_comb begin
        w_state_next = r_state;
        w_base_next  = r_base;
        w_idx_next   = r_idx;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_state_next = ST_FILL;
                else        w_clear      = 1'b1;
            end
            ST_FILL: begin
                if (!enable) begin
                    w_state_next = ST_IDLE;
                    w_clear      = 1'b1;
                end else if (w_occ >= C_FRAME_P) begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_frame_done) begin
                    w_idx_next  = '0;
                    w_base_next = r_base + C_HOP_P;
                    if (enable) begin
                        w_state_next = ST_FILL;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_clear      = 1'b1;
                    end
                end else if (w_xfer) begin
                    w_idx_next = r_idx + LW'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_clear      = 1'b1;
            end
        endcase
        if (w_clear) begin
            w_base_next = '0;
            w_idx_next  = '0;
        end
    end

    // State register with the streaming frame base and index
    always_ff @(posedge hclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_base  <= w_base_next;
            r_idx   <= w_idx_next;
        end
    end

    // Select the sample to write: a pending low half always goes before any new word
    assign w_word = enable && din_vld;
    always_comb begin
        w_wr_go = 1'b0;
        w_wr_x  = '0;
        if (r_pend) begin
            w_wr_go = 1'b1;
            w_wr_x  = r_pend_x;
        end else if (w_word) begin
            w_wr_go = 1'b1;
            w_wr_x  = double ? din[23:12] : din[11:0];
        end
    end

    assign w_wr_full = w_wr_go && !w_clear && (w_occ == C_DEPTH_P);
    assign w_wr_ok   = w_wr_go && !w_clear && (w_occ != C_DEPTH_P);
    assign w_s       = adc_to_s16(w_wr_x);
    assign w_y       = w_s - (r_prev - (r_prev >>> PREEMP_SHIFT));

    // Write pointer, pre-emphasis history and the pending second half of a double word
    always_ff @(posedge hclk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_prev   <= '0;
            r_pend   <= 1'b0;
            r_pend_x <= '0;
        end else begin
            if (r_pend) begin
                r_pend <= 1'b0;
            end else if (w_word && double) begin
                r_pend   <= 1'b1;
                r_pend_x <= din[11:0];
            end
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
                r_prev   <= w_s;
            end
            if (w_clear) begin
                r_wr_ptr <= '0;
                r_prev   <= '0;
                r_pend   <= 1'b0;
            end
        end
    end

    // Sticky overflow and emitted-frame counter survive a disable, only reset clears them
    always_ff @(posedge hclk) begin
        if (rst) begin
            r_ovf       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_wr_full || (r_pend && w_word)) begin
                r_ovf <= 1'b1;
            end
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    // Address for next cycle's output; a stalled beat re-reads the same, never-overwritten entry
    assign w_raddr = w_base_next[AW-1:0] + AW'(w_idx_next);

    framer_ram #(
        .DEPTH (C_DEPTH),
        .AW    (AW),
        .W     (16)
    ) u_ram (
        .i_clk   (hclk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (w_y),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign m_valid   = (r_state == ST_STREAM);
    assign m_first   = m_valid && (r_idx == '0);
    assign m_last    = m_valid && (r_idx == C_LAST_IDX);
    assign m_data    = m_valid ? w_rdata : 16'd0;
    assign overflow  = r_ovf;
    assign frame_cnt = r_frame_cnt;

endmodule
